// File: rtl/mastermind_game_ctrl_if.sv
// Board-side bundle for the Mastermind controller: start/secret/buttons in,
// board matrix, cursor, score and game-status out.
interface mastermind_game_ctrl_if #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 4
);
    logic                       start;
    logic [COLS*3-1:0]          secret;
    logic                       btn_left;
    logic                       btn_right;
    logic                       btn_up;
    logic                       btn_down;
    logic                       btn_center;
    logic [ROWS*COLS*3-1:0]     matrix_flat;
    logic [2:0]                 guess_num;
    logic                       q_Input;
    logic [1:0]                 cursor;
    logic [2:0]                 exact_cnt;
    logic [2:0]                 partial_cnt;
    logic                       fb_valid;
    logic                       win;
    logic                       lose;

    modport master (
        output start, secret, btn_left, btn_right, btn_up, btn_down, btn_center,
        input  matrix_flat, guess_num, q_Input, cursor, exact_cnt, partial_cnt,
               fb_valid, win, lose
    );

    modport slave (
        input  start, secret, btn_left, btn_right, btn_up, btn_down, btn_center,
        output matrix_flat, guess_num, q_Input, cursor, exact_cnt, partial_cnt,
               fb_valid, win, lose
    );
endinterface

// File: rtl/mastermind_game_ctrl.sv
// Mastermind game-state controller: guess entry, six-cycle colour-count scoring
// followed by a one-cycle evaluation, and win/lose tracking.
module mastermind_game_ctrl #(
    parameter int unsigned ROWS = 6,
    parameter int unsigned COLS = 4,
    parameter int unsigned NCOL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mastermind_game_ctrl_if.slave  bus
);
    localparam int unsigned RowW = COLS * 3;
    localparam int unsigned MatW = ROWS * RowW;

    typedef enum logic [2:0] {
        StIdle, StInput, StCheck, StEval, StDoneWin, StDoneLose
    } state_e;

    state_e            state_q, state_d;
    logic [RowW-1:0]   secret_q, secret_d;
    logic [MatW-1:0]   matrix_q, matrix_d;
    logic [2:0]        guess_num_q, guess_num_d;
    logic [1:0]        cursor_q, cursor_d;
    logic [2:0]        exact_q, exact_d;
    logic [2:0]        partial_q, partial_d;
    logic              fb_valid_q, fb_valid_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        acc_q, acc_d;

    function automatic logic [2:0] count_col(input logic [RowW-1:0] row, input logic [2:0] col);
        logic [2:0] n;
        n = '0;
        for (int c = 0; c < COLS; c++) begin
            if (row[3*c +: 3] == col) n = n + 3'd1;
        end
        return n;
    endfunction

    logic [RowW-1:0] row_cur, row_d;
    logic [2:0]      slot_cur, gcnt, scnt, exact_now;
    logic            secret_ok, row_full;

    always_comb begin
        row_cur  = matrix_q[guess_num_q*RowW +: RowW];
        slot_cur = row_cur[cursor_q*3 +: 3];
        gcnt     = count_col(row_cur, k_q);
        scnt     = count_col(secret_q, k_q);
        secret_ok = 1'b1;
        row_full  = 1'b1;
        exact_now = '0;
        for (int c = 0; c < COLS; c++) begin
            if (bus.secret[3*c +: 3] == 3'd0 || bus.secret[3*c +: 3] > 3'(NCOL)) secret_ok = 1'b0;
            if (row_cur[3*c +: 3] == 3'd0) row_full = 1'b0;
            if (row_cur[3*c +: 3] == secret_q[3*c +: 3]) exact_now = exact_now + 3'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        matrix_d    = matrix_q;
        guess_num_d = guess_num_q;
        cursor_d    = cursor_q;
        exact_d     = exact_q;
        partial_d   = partial_q;
        fb_valid_d  = 1'b0;
        k_d         = k_q;
        acc_d       = acc_q;
        row_d       = row_cur;

        // A valid start overrides everything, including an in-flight score.
        if (bus.start && secret_ok) begin
            state_d     = StInput;
            secret_d    = bus.secret;
            matrix_d    = '0;
            guess_num_d = '0;
            cursor_d    = '0;
            exact_d     = '0;
            partial_d   = '0;
        end else begin
            unique case (state_q)
                StInput: begin
                    if (bus.btn_center) begin
                        if (row_full) begin
                            state_d = StCheck;
                            k_d     = 3'd1;
                            acc_d   = '0;
                        end
                    end else if (bus.btn_up) begin
                        row_d[cursor_q*3 +: 3] = (slot_cur >= 3'(NCOL)) ? 3'd1 : slot_cur + 3'd1;
                    end else if (bus.btn_down) begin
                        row_d[cursor_q*3 +: 3] = (slot_cur <= 3'd1) ? 3'(NCOL) : slot_cur - 3'd1;
                    end else if (bus.btn_left) begin
                        cursor_d = cursor_q - 2'd1;
                    end else if (bus.btn_right) begin
                        cursor_d = cursor_q + 2'd1;
                    end
                    matrix_d[guess_num_q*RowW +: RowW] = row_d;
                end
                StCheck: begin
                    acc_d = acc_q + ((gcnt < scnt) ? gcnt : scnt);
                    if (k_q == 3'(NCOL)) state_d = StEval;
                    else                 k_d     = k_q + 3'd1;
                end
                StEval: begin
                    exact_d    = exact_now;
                    partial_d  = acc_q - exact_now;
                    fb_valid_d = 1'b1;
                    if (exact_now == 3'(COLS)) begin
                        state_d = StDoneWin;
                    end else if (guess_num_q == 3'(ROWS - 1)) begin
                        state_d = StDoneLose;
                    end else begin
                        guess_num_d = guess_num_q + 3'd1;
                        cursor_d    = '0;
                        state_d     = StInput;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            secret_q    <= '0;
            matrix_q    <= '0;
            guess_num_q <= '0;
            cursor_q    <= '0;
            exact_q     <= '0;
            partial_q   <= '0;
            fb_valid_q  <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            secret_q    <= secret_d;
            matrix_q    <= matrix_d;
            guess_num_q <= guess_num_d;
            cursor_q    <= cursor_d;
            exact_q     <= exact_d;
            partial_q   <= partial_d;
            fb_valid_q  <= fb_valid_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.matrix_flat = matrix_q;
    assign bus.guess_num   = guess_num_q;
    assign bus.q_Input     = (state_q == StInput);
    assign bus.cursor      = cursor_q;
    assign bus.exact_cnt   = exact_q;
    assign bus.partial_cnt = partial_q;
    assign bus.fb_valid    = fb_valid_q;
    assign bus.win         = (state_q == StDoneWin);
    assign bus.lose        = (state_q == StDoneLose);
endmodule

// File: tb/tb_mastermind_game_ctrl.sv
// Directed bench: stimulus pushes expected scores into a scoreboard, a monitor
// pops and compares on every fb_valid pulse.
module tb_mastermind_game_ctrl;
    localparam int BL = 0, BR = 1, BU = 2, BD = 3, BC = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mastermind_game_ctrl_if ifc ();

    mastermind_game_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    typedef struct packed {
        logic [2:0] ex;
        logic [2:0] pa;
        logic [2:0] gn;
        logic       win;
        logic       lose;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every fb_valid pulse must match the oldest expected score.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (rst_n && ifc.fb_valid) begin
                n_checks++;
                got = {ifc.exact_cnt, ifc.partial_cnt, ifc.guess_num, ifc.win, ifc.lose};
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL fb_valid_unexpected: got score %0h, required no pulse", got);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL score: got ex/pa/gn/win/lose %0h, required %0h", got, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b);
        case (b)
            BL: ifc.btn_left   = 1'b1;
            BR: ifc.btn_right  = 1'b1;
            BU: ifc.btn_up     = 1'b1;
            BD: ifc.btn_down   = 1'b1;
            default: ifc.btn_center = 1'b1;
        endcase
        tick(1);
        ifc.btn_left = 1'b0; ifc.btn_right = 1'b0; ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0; ifc.btn_center = 1'b0;
    endtask

    task automatic do_start(input logic [11:0] s);
        ifc.secret = s;
        ifc.start  = 1'b1;
        tick(1);
        ifc.start  = 1'b0;
    endtask

    // Fill an empty row from cursor 0; four rights bring the cursor back to 0.
    task automatic enter_row(input logic [11:0] g);
        for (int c = 0; c < 4; c++) begin
            repeat (int'(g[3*c +: 3])) press(BU);
            press(BR);
        end
    endtask

    localparam logic [11:0] S1234 = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [11:0] S1123 = {3'd3, 3'd2, 3'd1, 3'd1};
    localparam logic [11:0] G1211 = {3'd1, 3'd1, 3'd2, 3'd1};
    localparam logic [11:0] G5555 = {3'd5, 3'd5, 3'd5, 3'd5};

    initial begin
        ifc.start = 1'b0; ifc.secret = '0;
        ifc.btn_left = 1'b0; ifc.btn_right = 1'b0; ifc.btn_up = 1'b0;
        ifc.btn_down = 1'b0; ifc.btn_center = 1'b0;

        tick(2);
        chk("rst_matrix", ifc.matrix_flat, 72'h0);
        chk("rst_status", {ifc.guess_num, ifc.q_Input, ifc.cursor, ifc.win, ifc.lose}, 0);
        chk("rst_score", {ifc.exact_cnt, ifc.partial_cnt, ifc.fb_valid}, 0);
        rst_n = 1'b1;
        tick(1);

        // Secret with an empty slot must be ignored.
        do_start({3'd4, 3'd3, 3'd2, 3'd0});
        chk("bad_start_ignored", ifc.q_Input, 1'b0);

        do_start(S1234);
        chk("start_q_input", ifc.q_Input, 1'b1);
        chk("start_guess_num", ifc.guess_num, 3'd0);
        chk("start_matrix", ifc.matrix_flat, 72'h0);

        press(BL);
        chk("cursor_left_wrap", ifc.cursor, 2'd3);
        press(BR);
        chk("cursor_right_wrap", ifc.cursor, 2'd0);
        repeat (7) press(BU);
        chk("colour_up_wrap", ifc.matrix_flat[2:0], 3'd1);
        press(BD);
        chk("colour_down_wrap", ifc.matrix_flat[2:0], 3'd6);

        press(BC);
        tick(8);
        chk("center_incomplete_ignored", ifc.q_Input, 1'b1);

        // Complete row to {1,2,3,4}: a winning guess.
        press(BU);
        press(BR);
        for (int c = 1; c < 4; c++) begin
            repeat (c + 1) press(BU);
            press(BR);
        end
        chk("row_win_entered", ifc.matrix_flat, {60'h0, S1234});
        sb.push_back('{ex: 3'd4, pa: 3'd0, gn: 3'd0, win: 1'b1, lose: 1'b0});
        press(BC);
        chk("center_q_input_falls", ifc.q_Input, 1'b0);
        tick(6);
        chk("fb_not_before_eval", ifc.fb_valid, 1'b0);
        tick(1);
        chk("fb_at_eval", ifc.fb_valid, 1'b1);
        chk("win_level", ifc.win, 1'b1);
        press(BU);
        press(BL);
        chk("win_buttons_ignored", {ifc.matrix_flat, ifc.cursor}, {58'h0, S1234, 2'd0});

        // Mixed score: exact 1, partial 2.
        do_start(S1123);
        enter_row(G1211);
        sb.push_back('{ex: 3'd1, pa: 3'd2, gn: 3'd1, win: 1'b0, lose: 1'b0});
        press(BC);
        tick(8);
        chk("mixed_guess_num", ifc.guess_num, 3'd1);
        chk("mixed_q_input", ifc.q_Input, 1'b1);

        // Six misses end in DONE_LOSE.
        do_start(S1234);
        for (int i = 0; i < 6; i++) begin
            enter_row(G5555);
            sb.push_back('{ex: 3'd0, pa: 3'd0, gn: (i < 5) ? 3'(i + 1) : 3'd5,
                           win: 1'b0, lose: (i == 5)});
            press(BC);
            tick(8);
        end
        chk("lose_level", ifc.lose, 1'b1);
        chk("lose_guess_num", ifc.guess_num, 3'd5);

        // start mid-CHECK: no score pulse, fresh game.
        do_start(S1123);
        enter_row(G1211);
        press(BC);
        tick(3);
        do_start(S1234);
        tick(10);
        chk("abort_q_input", ifc.q_Input, 1'b1);
        chk("abort_matrix", ifc.matrix_flat, 72'h0);

        // start and a button together: button dropped.
        ifc.secret = S1234;
        ifc.start  = 1'b1;
        ifc.btn_up = 1'b1;
        tick(1);
        ifc.start  = 1'b0;
        ifc.btn_up = 1'b0;
        chk("start_beats_button", ifc.matrix_flat, 72'h0);

        // Asynchronous reset mid-game.
        press(BU);
        press(BR);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_matrix", ifc.matrix_flat, 72'h0);
        chk("async_rst_status", {ifc.q_Input, ifc.cursor, ifc.guess_num}, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
